// File: rtl/opt_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : opt_filter                                                    |
// | Purpose  : Per-channel output transform downstream of the PID filter.    |
// |            Each word is multiplied by a gain, arithmetically right       |
// |            shifted, offset, and clamped to [min,max]. The result is a    |
// |            DAC-width signed word.                                        |
// | Ports    : clk_in/rst_n_in      clock, async active-low reset            |
// |            dv_in/chan_in/data_in input word (signed PID sum)            |
// |            wr_en/wr_addr/wr_chan/wr_data  per-channel config writes      |
// |            dv_out/chan_out/data_out       transformed output word        |
// | Options  : OPT_FILTER_SLEW_LIMIT_EN adds a per-channel slew limiter      |
// |            stage (latency 5 instead of 4).                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module opt_filter #(
  parameter int                   W_CHAN        = 5,
  parameter int                   N_CHAN        = 8,
  parameter int                   W_DIN         = 128,
  parameter int                   W_DOUT        = 16,
  parameter int                   W_MULT        = 16,
  parameter int                   W_RS          = 8,
  parameter int                   W_WR_ADDR     = 16,
  parameter int                   W_WR_CHAN     = 16,
  parameter int                   W_WR_DATA     = 48,
  parameter logic [W_WR_ADDR-1:0] ADDR_MULT     = 16'h0030,
  parameter logic [W_WR_ADDR-1:0] ADDR_RS       = 16'h0031,
  parameter logic [W_WR_ADDR-1:0] ADDR_OFFSET   = 16'h0032,
  parameter logic [W_WR_ADDR-1:0] ADDR_MIN      = 16'h0033,
  parameter logic [W_WR_ADDR-1:0] ADDR_MAX      = 16'h0034,
  parameter logic [W_WR_ADDR-1:0] ADDR_MAX_STEP = 16'h0035
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DIN-1:0]     data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DOUT-1:0]    data_out
);

  localparam int W_PROD = W_DIN + W_MULT;
  localparam int W_SUM  = W_PROD + 1;
  localparam logic signed [W_MULT-1:0] MULT_ONE = {{(W_MULT-1){1'b0}}, 1'b1};
  localparam logic signed [W_DOUT-1:0] DOUT_MIN = {1'b1, {(W_DOUT-1){1'b0}}};
  localparam logic signed [W_DOUT-1:0] DOUT_MAX = {1'b0, {(W_DOUT-1){1'b1}}};

  // Config bits above the widest field are never used.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[W_WR_DATA-1:W_DOUT];

  // ---------------- per-channel configuration ----------------
  logic signed [W_MULT-1:0] mult_q [N_CHAN];
  logic        [W_RS-1:0]   rs_q   [N_CHAN];
  logic signed [W_DOUT-1:0] off_q  [N_CHAN];
  logic signed [W_DOUT-1:0] min_q  [N_CHAN];
  logic signed [W_DOUT-1:0] max_q  [N_CHAN];
`ifdef OPT_FILTER_SLEW_LIMIT_EN
  logic        [W_DOUT-2:0] step_q [N_CHAN];
  logic signed [W_DOUT-1:0] prev_q [N_CHAN];
`endif

  // Equality against every in-range index means wr_chan >= N_CHAN
  // (including high bits set) matches nothing and is dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        mult_q[i] <= MULT_ONE;
        rs_q[i]   <= '0;
        off_q[i]  <= '0;
        min_q[i]  <= DOUT_MIN;
        max_q[i]  <= DOUT_MAX;
`ifdef OPT_FILTER_SLEW_LIMIT_EN
        step_q[i] <= '0;
`endif
      end
    end else if (wr_en) begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (wr_chan == W_WR_CHAN'(i)) begin
          case (wr_addr)
            ADDR_MULT:     mult_q[i] <= wr_data[W_MULT-1:0];
            ADDR_RS:       rs_q[i]   <= wr_data[W_RS-1:0];
            ADDR_OFFSET:   off_q[i]  <= wr_data[W_DOUT-1:0];
            ADDR_MIN:      min_q[i]  <= wr_data[W_DOUT-1:0];
            ADDR_MAX:      max_q[i]  <= wr_data[W_DOUT-1:0];
`ifdef OPT_FILTER_SLEW_LIMIT_EN
            ADDR_MAX_STEP: step_q[i] <= wr_data[W_DOUT-2:0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- P1 fetch (reads pre-write config) ----------------
  logic signed [W_MULT-1:0] mult1_d;
  logic        [W_RS-1:0]   rs1_d;
  logic signed [W_DOUT-1:0] off1_d, min1_d, max1_d;
`ifdef OPT_FILTER_SLEW_LIMIT_EN
  logic        [W_DOUT-2:0] step1_d;
`endif

  always_comb begin
    mult1_d = MULT_ONE;
    rs1_d   = '0;
    off1_d  = '0;
    min1_d  = DOUT_MIN;
    max1_d  = DOUT_MAX;
`ifdef OPT_FILTER_SLEW_LIMIT_EN
    step1_d = '0;
`endif
    for (int i = 0; i < N_CHAN; i++) begin
      if (chan_in == W_CHAN'(i)) begin
        mult1_d = mult_q[i];
        rs1_d   = rs_q[i];
        off1_d  = off_q[i];
        min1_d  = min_q[i];
        max1_d  = max_q[i];
`ifdef OPT_FILTER_SLEW_LIMIT_EN
        step1_d = step_q[i];
`endif
      end
    end
  end

  // ---------------- pipeline registers ----------------
  logic                     dv1_q, dv2_q, dv3_q, dv4_q;
  logic        [W_CHAN-1:0] chan1_q, chan2_q, chan3_q, chan4_q;
  logic signed [W_DIN-1:0]  data1_q;
  logic signed [W_MULT-1:0] mult1_q;
  logic        [W_RS-1:0]   rs1_q, rs2_q;
  logic signed [W_DOUT-1:0] off1_q, off2_q;
  logic signed [W_DOUT-1:0] min1_q, min2_q, min3_q, min4_q;
  logic signed [W_DOUT-1:0] max1_q, max2_q, max3_q, max4_q;
  logic signed [W_PROD-1:0] prod2_q;
  logic signed [W_SUM-1:0]  sum3_q;
  logic signed [W_DOUT-1:0] clamp4_q;
  logic        [W_DOUT-2:0] step1_q, step2_q, step3_q, step4_q;
  logic signed [W_DOUT-1:0] clamp4_d;
  logic signed [W_SUM-1:0]  lo4_d;

`ifndef OPT_FILTER_SLEW_LIMIT_EN
  // Step field only exists with the slew limiter; tie it off here.
  logic [W_DOUT-2:0] step1_d;
  assign step1_d = '0;
  logic unused_slew;
  assign unused_slew = ^{step4_q, min4_q, max4_q};
`endif

  // P4 clamp: min first, then max, so min>max resolves to max.
  always_comb begin
    lo4_d    = (sum3_q < W_SUM'(min3_q)) ? W_SUM'(min3_q) : sum3_q;
    clamp4_d = (lo4_d > W_SUM'(max3_q)) ? max3_q : lo4_d[W_DOUT-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      {dv1_q, dv2_q, dv3_q, dv4_q}         <= '0;
      {chan1_q, chan2_q, chan3_q, chan4_q} <= '0;
      data1_q  <= '0;  mult1_q <= '0;  rs1_q  <= '0;  off1_q <= '0;
      min1_q   <= '0;  max1_q  <= '0;  step1_q <= '0;
      prod2_q  <= '0;  rs2_q   <= '0;  off2_q <= '0;
      min2_q   <= '0;  max2_q  <= '0;  step2_q <= '0;
      sum3_q   <= '0;  min3_q  <= '0;  max3_q <= '0;  step3_q <= '0;
      clamp4_q <= '0;  min4_q  <= '0;  max4_q <= '0;  step4_q <= '0;
    end else begin
      // P1
      dv1_q   <= dv_in;    chan1_q <= chan_in;  data1_q <= data_in;
      mult1_q <= mult1_d;  rs1_q   <= rs1_d;    off1_q  <= off1_d;
      min1_q  <= min1_d;   max1_q  <= max1_d;   step1_q <= step1_d;
      // P2: exact signed product
      dv2_q   <= dv1_q;    chan2_q <= chan1_q;
      prod2_q <= W_PROD'(data1_q) * W_PROD'(mult1_q);
      rs2_q   <= rs1_q;    off2_q  <= off1_q;
      min2_q  <= min1_q;   max2_q  <= max1_q;   step2_q <= step1_q;
      // P3: sign-filled shift then offset with one guard bit
      dv3_q   <= dv2_q;    chan3_q <= chan2_q;
      sum3_q  <= W_SUM'(prod2_q >>> rs2_q) + W_SUM'(off2_q);
      min3_q  <= min2_q;   max3_q  <= max2_q;   step3_q <= step2_q;
      // P4
      dv4_q    <= dv3_q;   chan4_q <= chan3_q;  clamp4_q <= clamp4_d;
      min4_q   <= min3_q;  max4_q  <= max3_q;   step4_q  <= step3_q;
    end
  end

`ifdef OPT_FILTER_SLEW_LIMIT_EN
  // ---------------- P5 slew limiter ----------------
  localparam int W_EXT = W_DOUT + 1;
  logic signed [W_EXT-1:0]  prev5_d, clamp5_d, delta5_d, mag5_d, step5_d;
  logic signed [W_EXT-1:0]  slew5_d, lo5_d;
  logic signed [W_DOUT-1:0] out5_d;
  logic                     dv5_q;
  logic        [W_CHAN-1:0] chan5_q;
  logic signed [W_DOUT-1:0] out5_q;

  always_comb begin
    prev5_d = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (chan4_q == W_CHAN'(i)) prev5_d = W_EXT'(prev_q[i]);
    end
    clamp5_d = W_EXT'(clamp4_q);
    step5_d  = signed'({2'b00, step4_q});
    delta5_d = clamp5_d - prev5_d;
    mag5_d   = delta5_d[W_EXT-1] ? -delta5_d : delta5_d;
    if ((step4_q != '0) && (mag5_d > step5_d)) begin
      slew5_d = delta5_d[W_EXT-1] ? (prev5_d - step5_d) : (prev5_d + step5_d);
    end else begin
      slew5_d = clamp5_d;
    end
    lo5_d  = (slew5_d < W_EXT'(min4_q)) ? W_EXT'(min4_q) : slew5_d;
    out5_d = (lo5_d > W_EXT'(max4_q)) ? max4_q : lo5_d[W_DOUT-1:0];
  end

  // prev is committed on the same edge the result is registered, so a
  // back-to-back word on the same channel reads the fresh value in P5.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dv5_q   <= 1'b0;
      chan5_q <= '0;
      out5_q  <= '0;
      for (int i = 0; i < N_CHAN; i++) prev_q[i] <= '0;
    end else begin
      dv5_q   <= dv4_q;
      chan5_q <= chan4_q;
      out5_q  <= out5_d;
      for (int i = 0; i < N_CHAN; i++) begin
        if (dv4_q && (chan4_q == W_CHAN'(i))) prev_q[i] <= out5_d;
      end
    end
  end

  assign dv_out   = dv5_q;
  assign chan_out = chan5_q;
  assign data_out = out5_q;
`else
  assign dv_out   = dv4_q;
  assign chan_out = chan4_q;
  assign data_out = clamp4_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_opt_filter.sv
`default_nettype none
module tb_opt_filter;
  localparam int N_CHAN = 8;
`ifdef OPT_FILTER_SLEW_LIMIT_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dv_in = 1'b0;
  logic [4:0]   chan_in = '0;
  logic [127:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic [15:0]  wr_addr = '0;
  logic [15:0]  wr_chan = '0;
  logic [47:0]  wr_data = '0;
  logic         dv_out;
  logic [4:0]   chan_out;
  logic [15:0]  data_out;

  always #5 clk = ~clk;

  opt_filter dut (
    .clk_in(clk), .rst_n_in(rst_n), .dv_in(dv_in), .chan_in(chan_in),
    .data_in(data_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan),
    .wr_data(wr_data), .dv_out(dv_out), .chan_out(chan_out), .data_out(data_out)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  chan;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural reference model ----------------
  int m_mult[N_CHAN], m_rs[N_CHAN], m_off[N_CHAN], m_min[N_CHAN], m_max[N_CHAN];
  int m_step[N_CHAN], m_prev[N_CHAN];

  task automatic model_reset();
    for (int i = 0; i < N_CHAN; i++) begin
      m_mult[i] = 1; m_rs[i] = 0; m_off[i] = 0;
      m_min[i] = -32768; m_max[i] = 32767; m_step[i] = 0; m_prev[i] = 0;
    end
  endtask

  task automatic model_write(input int wa, input int wc, input longint wd);
    if (wc >= 0 && wc < N_CHAN) begin
      case (wa)
        'h30: m_mult[wc] = $signed(wd[15:0]);
        'h31: m_rs[wc]   = int'(wd[7:0]);
        'h32: m_off[wc]  = $signed(wd[15:0]);
        'h33: m_min[wc]  = $signed(wd[15:0]);
        'h34: m_max[wc]  = $signed(wd[15:0]);
`ifdef OPT_FILTER_SLEW_LIMIT_EN
        'h35: m_step[wc] = int'(wd[14:0]);
`endif
        default: ;
      endcase
    end
  endtask

  function automatic int ref_out(input int ch, input logic signed [127:0] d);
    logic signed [144:0] v;
    int c;
    v = d;
    v = v * m_mult[ch];
    v = v >>> m_rs[ch];
    v = v + m_off[ch];
    if (v < m_min[ch]) v = m_min[ch];
    if (v > m_max[ch]) v = m_max[ch];
    c = signed'(v[31:0]);
`ifdef OPT_FILTER_SLEW_LIMIT_EN
    if (m_step[ch] != 0 && (c - m_prev[ch] > m_step[ch] || m_prev[ch] - c > m_step[ch]))
      c = (c > m_prev[ch]) ? m_prev[ch] + m_step[ch] : m_prev[ch] - m_step[ch];
    if (c < m_min[ch]) c = m_min[ch];
    if (c > m_max[ch]) c = m_max[ch];
    m_prev[ch] = c;
`endif
    return c;
  endfunction

  // One clock of stimulus; expected result uses config as it was before
  // any write issued in the same cycle.
  task automatic step(input bit dv, input int ch, input logic signed [127:0] d,
                      input bit we = 0, input int wa = 0, input int wc = 0,
                      input longint wd = 0);
    exp_t e;
    dv_in = dv; chan_in = ch[4:0]; data_in = d;
    wr_en = we; wr_addr = wa[15:0]; wr_chan = wc[15:0]; wr_data = wd[47:0];
    if (dv) begin
      e.cyc  = cyc + LAT;
      e.chan = ch[4:0];
      e.data = 16'(ref_out(ch, d));
      sb.push_back(e);
    end
    if (we) model_write(wa, wc, wd);
    @(posedge clk); #1;
    dv_in = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && dv_out) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dv: got chan=%0d data=%0d at cyc %0d, expected no output",
                 chan_out, $signed(data_out), cyc);
      end else begin
        e = sb.pop_front();
        if (chan_out !== e.chan || data_out !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL out_word: got chan=%0d data=%0d cyc=%0d, expected chan=%0d data=%0d cyc=%0d",
                   chan_out, $signed(data_out), cyc, e.chan, $signed(e.data), e.cyc);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string name);
    n_tests++;
    if (dv_out !== 1'b0 || chan_out !== '0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL %s: got dv=%0b chan=%0d data=%0d, expected all 0",
               name, dv_out, chan_out, data_out);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic signed [127:0] d;
    int wa, wc;
    longint wd;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_outputs");
    rst_n = 1'b1;

    // reset defaults
    step(1, 2, 1234);
    step(1, 2, 40000);
    step(1, 2, -40000);

    // gain / shift / offset on chan 1
    step(0, 0, 0, 1, 'h30, 1, 3);
    step(0, 0, 0, 1, 'h31, 1, 2);
    step(0, 0, 0, 1, 'h32, 1, -10);
    step(1, 1, 100);
    step(1, 1, -7);

    // clamp on chan 0, then min > max
    step(0, 0, 0, 1, 'h33, 0, -100);
    step(0, 0, 0, 1, 'h34, 0, 200);
    step(1, 0, 500);
    step(1, 0, -500);
    step(1, 0, 50);
    step(0, 0, 0, 1, 'h33, 0, 300);
    step(1, 0, 0);

    // write/fetch race on chan 3
    step(1, 3, 10, 1, 'h30, 3, 2);
    step(1, 3, 10);

    // invalid channels and unknown address change nothing
    step(0, 0, 0, 1, 'h30, 8, 5);
    step(0, 0, 0, 1, 'h30, 'h100, 5);
    step(0, 0, 0, 1, 'h30, 'h108, 5);
    step(0, 0, 0, 1, 'h36, 2, 7);
    step(1, 0, 150);
    step(1, 2, 777);

    // slew: ignored without the limiter
    step(0, 0, 0, 1, 'h35, 4, 10);
    step(1, 4, 100);
    step(1, 4, 100);
    step(1, 4, -5);

    // streaming all channels back to back
    for (int i = 0; i < N_CHAN; i++) step(1, i, $signed($urandom_range(0, 60000)) - 30000);
    idle(LAT + 2);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       d = {$urandom, $urandom, $urandom, $urandom};
        default: d = $signed($urandom_range(0, 200000)) - 100000;
      endcase
      wa = 'h30 + $urandom_range(0, 6);
      wc = $urandom_range(0, 9);
      case (wa)
        'h30: wd = ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 16)) - 8;
        'h31: wd = ($urandom_range(0, 7) == 0) ? longint'($urandom_range(0, 255)) : longint'($urandom_range(0, 24));
        'h33: wd = ($urandom_range(0, 7) == 0) ? longint'($urandom) : -longint'($urandom_range(0, 30000));
        'h34: wd = ($urandom_range(0, 7) == 0) ? longint'($urandom) : longint'($urandom_range(0, 30000));
        'h35: wd = longint'($urandom_range(0, 2000));
        default: wd = longint'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0)
        step(1, $urandom_range(0, N_CHAN - 1), d, $urandom_range(0, 3) == 0, wa, wc, wd);
      else
        step(0, $urandom_range(0, 31), d, $urandom_range(0, 3) == 0, wa, wc, wd);
    end
    idle(LAT + 2);

    // reset with three words in flight
    step(1, 5, 11);
    step(1, 6, 22);
    step(1, 7, 33);
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check_zero_outputs("midflight_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(LAT + 4);

    // operation resumes with defaults
    step(1, 1, 100);
    idle(LAT + 2);

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding words, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
